// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL lock flag and produces a stretched, synchronous active-low
// reset for logic on the PLL output clock. It also keeps a saturating count of lock losses.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_FILTER = 1024,
    parameter int RESET_HOLD  = 16,
    parameter int DROP_FILTER = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             clear_count,
    output logic             rst_out_n,
    output logic [1:0]       state,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int PH_MAX = (LOCK_FILTER > RESET_HOLD) ? LOCK_FILTER : RESET_HOLD;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int DR_W   = $clog2(DROP_FILTER + 1);

    localparam logic [PH_W-1:0]  LF_LAST  = PH_W'(LOCK_FILTER - 1);
    localparam logic [PH_W-1:0]  RH_LAST  = PH_W'(RESET_HOLD - 1);
    localparam logic [DR_W-1:0]  DF_LAST  = DR_W'(DROP_FILTER - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_e                 state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [DR_W-1:0]        drop_q, drop_d;
    logic                   rst_out_q, rst_out_d;
    logic                   lock_lost_q, lock_lost_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   locked_s;
    logic                   loss;

    assign locked_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], locked};
        state_d = state_q;
        phase_d = phase_q;
        drop_d  = '0;
        loss    = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                phase_d = '0;
                if (locked_s) state_d = FILTER;
            end
            FILTER: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (phase_q == LF_LAST) begin
                    state_d = HOLD;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (phase_q == RH_LAST) begin
                    state_d = RUN;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            RUN: begin
                // Only a sustained synchronized low counts as a loss.
                if (!locked_s) begin
                    if (drop_q == DF_LAST) begin
                        state_d = WAIT_LOCK;
                        loss    = 1'b1;
                    end else begin
                        drop_d = drop_q + 1'b1;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        rst_out_d   = (state_d == RUN);
        lock_lost_d = loss;

        // A loss on the same edge as a clear leaves the count at one.
        count_d = count_q;
        if (clear_count) count_d = '0;
        if (loss) begin
            if (clear_count)          count_d = CNT_W'(1);
            else if (count_q != CNT_SAT) count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sync_q      <= '0;
            state_q     <= WAIT_LOCK;
            phase_q     <= '0;
            drop_q      <= '0;
            rst_out_q   <= 1'b0;
            lock_lost_q <= 1'b0;
            count_q     <= '0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            phase_q     <= phase_d;
            drop_q      <= drop_d;
            rst_out_q   <= rst_out_d;
            lock_lost_q <= lock_lost_d;
            count_q     <= count_d;
        end
    end

    assign rst_out_n       = rst_out_q;
    assign state           = state_q;
    assign lock_lost       = lock_lost_q;
    assign lock_loss_count = count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: a clean-lock vector table plus
// hand-written sequences for chatter, glitch, loss, saturation and reset corners.
module tb_pll_lock_supervisor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       locked = 1'b0;
    logic       clear_count = 1'b0;
    logic       rst_out_n;
    logic [1:0] state;
    logic       lock_lost;
    logic [1:0] lock_loss_count;

    int n_checks = 0;
    int n_pass   = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES(2), .LOCK_FILTER(8), .RESET_HOLD(4), .DROP_FILTER(4), .CNT_W(2)
    ) dut (
        .clock(clock), .reset_n(reset_n), .locked(locked), .clear_count(clear_count),
        .rst_out_n(rst_out_n), .state(state), .lock_lost(lock_lost),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       lk;
        logic       rst;
        logic [1:0] st;
        logic       lost;
        logic [1:0] cnt;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic wait_run(input string nm);
        int i;
        locked = 1'b1;
        i = 0;
        while (state != 2'd3 && i < 40) begin
            step();
            i++;
        end
        chk({nm, "_run_reached"}, int'(state == 2'd3), 1);
        chk({nm, "_rst_high"}, rst_out_n, 1);
    endtask

    // Drives a sustained low from edge d; the loss lands on edge d+5.
    task automatic do_loss(input string nm, input logic clr, input int exp_cnt);
        locked = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk({nm, "_rst_before"}, rst_out_n, 1);
        chk({nm, "_lost_before"}, lock_lost, 0);
        clear_count = clr;
        step();
        clear_count = 1'b0;
        chk({nm, "_rst_fall"}, rst_out_n, 0);
        chk({nm, "_lost_pulse"}, lock_lost, 1);
        chk({nm, "_state"}, state, 0);
        chk({nm, "_count"}, lock_loss_count, exp_cnt);
        step();
        chk({nm, "_lost_clear"}, lock_lost, 0);
    endtask

    initial begin
        for (int e = 0; e < 16; e++) begin
            vecs[e].lk   = 1'b1;
            vecs[e].lost = 1'b0;
            vecs[e].cnt  = 2'd0;
            vecs[e].rst  = (e >= 14);
            vecs[e].st   = (e < 2) ? 2'd0 : (e < 10) ? 2'd1 : (e < 14) ? 2'd2 : 2'd3;
        end

        // Reset state
        reset_n = 1'b0;
        locked  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("reset_rst", rst_out_n, 0);
        chk("reset_state", state, 0);
        chk("reset_lost", lock_lost, 0);
        chk("reset_count", lock_loss_count, 0);

        // Clean lock, edge 0 is the first edge with reset_n high
        reset_n = 1'b1;
        for (int e = 0; e < 16; e++) begin
            locked = vecs[e].lk;
            step();
            chk($sformatf("clean_rst_e%0d", e), rst_out_n, vecs[e].rst);
            chk($sformatf("clean_state_e%0d", e), state, vecs[e].st);
            chk($sformatf("clean_lost_e%0d", e), lock_lost, vecs[e].lost);
            chk($sformatf("clean_cnt_e%0d", e), lock_loss_count, vecs[e].cnt);
        end

        // RUN glitch of 3 low cycles is ignored
        locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("glitch_rst_%0d", i), rst_out_n, 1);
        end
        locked = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("glitch_rst_after_%0d", i), rst_out_n, 1);
            chk($sformatf("glitch_lost_%0d", i), lock_lost, 0);
        end

        // 4-cycle low (held) is a loss at d+5
        do_loss("loss1", 1'b0, 1);

        // Chatter in FILTER: one low restarts qualification, not a loss
        for (int e = 0; e <= 20; e++) begin
            locked = (e == 5) ? 1'b0 : 1'b1;
            step();
            chk($sformatf("chat_lost_e%0d", e), lock_lost, 0);
            if (e == 4)  chk("chat_filter_e4", state, 1);
            if (e == 7)  chk("chat_wait_e7", state, 0);
            if (e == 8)  chk("chat_filter_e8", state, 1);
            if (e == 19) chk("chat_rst_e19", rst_out_n, 0);
            if (e == 20) chk("chat_rst_e20", rst_out_n, 1);
        end
        chk("chat_count", lock_loss_count, 1);

        // Saturation and clear interaction
        do_loss("loss2", 1'b0, 2);
        wait_run("relock2");
        do_loss("loss3", 1'b0, 3);
        wait_run("relock3");
        do_loss("loss4_sat", 1'b0, 3);
        wait_run("relock4");
        do_loss("loss5_clr", 1'b1, 1);
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        chk("clear_alone", lock_loss_count, 0);

        // Reset mid-RUN with a nonzero count
        wait_run("relock5");
        do_loss("loss6", 1'b0, 1);
        wait_run("relock6");
        reset_n = 1'b0;
        step();
        chk("midrst_rst", rst_out_n, 0);
        chk("midrst_state", state, 0);
        chk("midrst_lost", lock_lost, 0);
        chk("midrst_count", lock_loss_count, 0);
        reset_n = 1'b1;
        for (int e = 0; e <= 14; e++) begin
            step();
            chk($sformatf("midrst_lost_e%0d", e), lock_lost, 0);
            if (e == 13) chk("midrst_rst_e13", rst_out_n, 0);
            if (e == 14) chk("midrst_rst_e14", rst_out_n, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Qualifies the PLL `locked` flag and generates the clean, synchronous, active-low reset that the fabric logic running on the PLL output clock uses. Sits directly downstream of the iCE40 PLL wrapper, clocked by its 25 MHz output. It synchronizes `locked`, requires it to hold stable before releasing reset, and stretches reset after release. It reasserts reset on a sustained lock loss and keeps a saturating count of loss events.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for `locked` (≥2).
- `LOCK_FILTER`, 1024: consecutive synchronized-high cycles required before reset stretch begins (≥1).
- `RESET_HOLD`, 16: cycles `rst_out_n` stays low after lock is qualified (≥1).
- `DROP_FILTER`, 4: consecutive synchronized-low cycles in RUN that constitute a lock loss (≥1).
- `CNT_W`, 8: width of loss counter.

Ports:
- `clock` in 1: PLL output clock; all logic on rising edge.
- `reset_n` in 1: one clock; reset is synchronous and active-low.
- `locked` in 1: raw PLL LOCK, asynchronous to `clock`.
- `clear_count` in 1: synchronous clear of `lock_loss_count`.
- `rst_out_n` out 1: downstream synchronous active-low reset, registered.
- `state` out 2: 0 WAIT_LOCK, 1 FILTER, 2 HOLD, 3 RUN.
- `lock_lost` out 1: one-cycle pulse on each counted lock loss.
- `lock_loss_count` out CNT_W: saturating count of lock losses.

## Operation
- `locked` passes through a SYNC_STAGES flop chain. `locked_s` is the last stage.
- One phase counter is shared by FILTER and HOLD. Its width is clog2(max(LOCK_FILTER, RESET_HOLD)+1). A separate drop counter is clog2(DROP_FILTER+1) wide.
- WAIT_LOCK: `rst_out_n`=0. When `locked_s`=1, go to FILTER and clear the phase counter.
- FILTER: `rst_out_n`=0.
  - `locked_s`=0 → WAIT_LOCK. This is not counted as a loss.
  - Otherwise, on phase counter == LOCK_FILTER-1 → HOLD and clear the counter; else increment.
- HOLD: `rst_out_n`=0.
  - `locked_s`=0 → WAIT_LOCK. Not counted.
  - Otherwise, on phase counter == RESET_HOLD-1 → RUN; else increment.
- RUN: `rst_out_n`=1.
  - The drop counter increments on each `locked_s`=0 cycle and clears on any `locked_s`=1 cycle.
  - When `locked_s`=0 and drop counter == DROP_FILTER-1 → WAIT_LOCK. On the same edge, pulse `lock_lost` and increment `lock_loss_count`, saturating at 2^CNT_W-1.
- `rst_out_n` is registered from the next state: it is 1 exactly when the registered state is RUN.
- `clear_count` zeroes the count. If a loss event occurs on the same edge, the count becomes 1 (the loss wins over the clear).

## Timing
- Reset (`reset_n`=0 at an edge):
  - synchronizer flops, both counters and state cleared to 0 (WAIT_LOCK);
  - `rst_out_n`=0, `lock_lost`=0, `lock_loss_count`=0.
- Reset mid-operation: `rst_out_n` falls at that edge regardless of state. The loss count is cleared and no `lock_lost` pulse is generated.
- Lock-up latency: `locked` is high and meets setup at edge 0 and stays high. `rst_out_n` rises at edge SYNC_STAGES+LOCK_FILTER+RESET_HOLD (edge 1042 at defaults).
- Loss latency: `locked` is low from edge d onward while in RUN. `rst_out_n` falls, and `lock_lost` pulses, at edge d+SYNC_STAGES+DROP_FILTER-1.
- Low glitches shorter than DROP_FILTER cycles (after synchronization) in RUN are ignored. Any synchronized low in FILTER/HOLD restarts qualification from WAIT_LOCK.
- After a loss, re-qualification takes the full lock-up latency. Outputs have no combinational paths from inputs.

## Test plan
Bench parameters: SYNC_STAGES=2, LOCK_FILTER=8, RESET_HOLD=4, DROP_FILTER=4, CNT_W=2.
- Clean lock: release `reset_n`, raise `locked` before edge 0 → `rst_out_n` is 0 through edge 13 and 1 from edge 14. `state` steps 0→1 (edge 2)→2 (edge 10)→3 (edge 14).
- Lock chatter in FILTER: `locked` drops for 1 cycle during FILTER → state returns to 0, `lock_loss_count` stays 0, and the full 14-cycle latency restarts from the next high.
- RUN glitch: in RUN, `locked` low for 3 cycles → `rst_out_n` stays 1, no `lock_lost`. Low for 4 cycles from edge d → `rst_out_n`=0 and `lock_lost`=1 at edge d+5, count=1.
- Saturation/clear: force 4 losses → count 3 (saturated). Assert `clear_count` on the same edge as a 5th loss → count=1. Assert `clear_count` alone → count=0.
- Reset mid-RUN: `reset_n`=0 for one edge while in RUN → `rst_out_n`=0 and state 0 at that edge, with no `lock_lost` pulse and count=0. With `locked` still high, `rst_out_n` returns 14 edges after `reset_n` deasserts.
